// File: rtl/ddr_cfg_seq_responder_if.sv
// Reset/start/done handshake between the DDR reset controller (master) and
// the configuration-sequencer responder (slave), plus the responder's debug taps.
interface ddr_cfg_seq_responder_if;
    logic       cfg_reset;
    logic       cfg_start;
    logic       axi_rstn;
    logic       cfg_done;
    logic       axi_ready;
    logic       busy;
    logic [2:0] phase;
    logic       mrs_pulse;
    logic [2:0] mrs_idx;
    logic [2:0] err;

    modport master (
        output cfg_reset, cfg_start, axi_rstn,
        input  cfg_done, axi_ready, busy, phase, mrs_pulse, mrs_idx, err
    );

    modport slave (
        input  cfg_reset, cfg_start, axi_rstn,
        output cfg_done, axi_ready, busy, phase, mrs_pulse, mrs_idx, err
    );
endinterface

// File: rtl/ddr_cfg_seq_responder.sv
// Emulates the hard-IP DDR configuration sequencer (power-up, MRS loads,
// calibration) and answers cfg_done; latches sticky handshake-violation flags.
module ddr_cfg_seq_responder #(
    parameter int pPwrUpCycles = 16,
    parameter int pMrsCount    = 4,
    parameter int pMrsGap      = 8,
    parameter int pCalCycles   = 32,
    parameter int pCntBitWidth = 16
) (
    input  logic                    iCLK,
    input  logic                    inRST,
    ddr_cfg_seq_responder_if.slave  cfg_if
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PWRUP = 3'd1,
        ST_MRS   = 3'd2,
        ST_CAL   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [pCntBitWidth-1:0] CNT_ZERO   = '0;
    localparam logic [pCntBitWidth-1:0] CNT_ONE    = pCntBitWidth'(1);
    localparam logic [pCntBitWidth-1:0] PWRUP_LAST = pCntBitWidth'(pPwrUpCycles - 1);
    localparam logic [pCntBitWidth-1:0] GAP_LAST   = pCntBitWidth'(pMrsGap - 1);
    localparam logic [pCntBitWidth-1:0] CAL_LAST   = pCntBitWidth'(pCalCycles - 1);
    localparam logic [2:0]              MRS_LAST   = 3'(pMrsCount - 1);

    state_t                  state_reg, state_next;
    logic [pCntBitWidth-1:0] cnt_reg, cnt_next;
    logic [2:0]              idx_reg, idx_next;
    logic [2:0]              err_reg, err_next;
    logic                    done_reg;
    logic                    busy_reg;
    logic                    pulse_reg;
    logic                    axi_ready_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        err_next   = err_reg;

        if (cfg_if.axi_rstn && state_reg != ST_DONE) begin
            err_next[1] = 1'b1;
        end

        if (cfg_if.cfg_reset) begin
            state_next = ST_IDLE;
            cnt_next   = CNT_ZERO;
            if (state_reg != ST_IDLE) begin
                err_next[2] = 1'b1;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_if.cfg_start) begin
                        state_next = ST_PWRUP;
                        cnt_next   = CNT_ZERO;
                        idx_next   = 3'd0;
                    end
                end
                ST_PWRUP, ST_MRS, ST_CAL: begin
                    if (!cfg_if.cfg_start) begin
                        state_next  = ST_IDLE;
                        cnt_next    = CNT_ZERO;
                        err_next[0] = 1'b1;
                    end else if (state_reg == ST_PWRUP) begin
                        if (cnt_reg == PWRUP_LAST) begin
                            state_next = ST_MRS;
                            cnt_next   = CNT_ZERO;
                            idx_next   = 3'd0;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end else if (state_reg == ST_MRS) begin
                        // Each slot is pMrsGap cycles; the last slot hands over to calibration.
                        if (cnt_reg == GAP_LAST) begin
                            cnt_next = CNT_ZERO;
                            if (idx_reg == MRS_LAST) begin
                                state_next = ST_CAL;
                            end else begin
                                idx_next = idx_reg + 3'd1;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end else begin
                        if (cnt_reg == CAL_LAST) begin
                            state_next = ST_DONE;
                            cnt_next   = CNT_ZERO;
                        end else begin
                            cnt_next = cnt_reg + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs are derived from the next-state values so they line up with the phase.
    always_ff @(posedge iCLK) begin
        if (!inRST) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= CNT_ZERO;
            idx_reg       <= 3'd0;
            err_reg       <= 3'd0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            pulse_reg     <= 1'b0;
            axi_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            err_reg       <= err_next;
            done_reg      <= (state_next == ST_DONE);
            busy_reg      <= (state_next == ST_PWRUP) || (state_next == ST_MRS) ||
                             (state_next == ST_CAL);
            pulse_reg     <= (state_next == ST_MRS) && (cnt_next == CNT_ZERO);
            axi_ready_reg <= done_reg && cfg_if.axi_rstn;
        end
    end

    assign cfg_if.cfg_done  = done_reg;
    assign cfg_if.axi_ready = axi_ready_reg;
    assign cfg_if.busy      = busy_reg;
    assign cfg_if.phase     = state_reg;
    assign cfg_if.mrs_pulse = pulse_reg;
    assign cfg_if.mrs_idx   = idx_reg;
    assign cfg_if.err       = err_reg;

endmodule
